// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch queue between fetch and decode stages
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc4,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_pc8,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  // One spare pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc4   [DEPTH];

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  // Handshakes come only from registered pointers, so a full queue never
  // accepts a push in the same cycle decode frees a slot.
  assign in_ready  = !full;
  assign out_valid = !empty;

  // A redirect kills both handshakes so the in-flight fetch and the head are
  // both left untouched by the pointer update.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign count = wr_ptr - rd_ptr;

  // An empty queue presents a NOP at PC 0 so decode sees a harmless head.
  assign out_instr = empty ? 32'h0000_0000 : mem_instr[rd_idx];
  assign out_pc4   = empty ? 32'h0000_0000 : mem_pc4[rd_idx];
  assign out_pc8   = out_pc4 + 32'd4;

  // Pointer update: flush rewinds both pointers to zero, otherwise advance on handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage is written only by an accepted push and is never cleared.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      mem_instr[wr_idx] <= in_instr;
      mem_pc4[wr_idx]   <= in_pc4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc4;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc4;
  logic [31:0]   out_pc8;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q[$];

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        ordy;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    int          exp_count;
  } vec_t;

  vec_t vt[9];

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc4(in_pc4), .in_ready(in_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc4(out_pc4), .out_pc8(out_pc8),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input string ctx);
    logic [31:0] e_ins, e_p4;
    e_ins = 32'h0;
    e_p4  = 32'h0;
    if (q.size() != 0) begin
      e_ins = q[0][63:32];
      e_p4  = q[0][31:0];
    end
    chk({ctx, " out_valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk({ctx, " in_ready"},  {31'b0, in_ready},  {31'b0, q.size() < DEPTH});
    chk({ctx, " count"},     {29'b0, count},     q.size());
    chk({ctx, " out_instr"}, out_instr, e_ins);
    chk({ctx, " out_pc4"},   out_pc4,   e_p4);
    chk({ctx, " out_pc8"},   out_pc8,   e_p4 + 32'd4);
  endtask

  // One clock: drive, check model before the edge, advance model after it.
  task automatic cyc(input string ctx, input logic iv, input logic [31:0] ins,
                     input logic [31:0] p4, input logic ordy, input logic fl);
    int  sz;
    logic do_push, do_pop;
    in_valid = iv; in_instr = ins; in_pc4 = p4; out_ready = ordy; flush = fl;
    #1;
    model_check(ctx);
    sz = q.size();
    do_push = iv && (sz < DEPTH) && !fl;
    do_pop  = ordy && (sz != 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({ins, p4});
    end
    #1;
  endtask

  initial begin
    logic [31:0] w;
    vt[0] = '{1'b1, 32'h24020001, 32'h00003004, 1'b0, 1'b1, 1'b1, 32'h24020001, 32'h00003004, 1};
    vt[1] = '{1'b1, 32'h8C430004, 32'h00003008, 1'b0, 1'b1, 1'b1, 32'h24020001, 32'h00003004, 2};
    vt[2] = '{1'b1, 32'h00831020, 32'h0000300C, 1'b0, 1'b1, 1'b1, 32'h24020001, 32'h00003004, 3};
    vt[3] = '{1'b1, 32'hAC820008, 32'h00003010, 1'b0, 1'b1, 1'b0, 32'h24020001, 32'h00003004, 4};
    vt[4] = '{1'b1, 32'hDEADBEEF, 32'h00003014, 1'b0, 1'b1, 1'b0, 32'h24020001, 32'h00003004, 4};
    vt[5] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'h8C430004, 32'h00003008, 3};
    vt[6] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'h00831020, 32'h0000300C, 2};
    vt[7] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'hAC820008, 32'h00003010, 1};
    vt[8] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 0};

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc4 = '0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst count",     {29'b0, count},     32'd0);
    chk("rst out_pc8",   out_pc8,            32'd4);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Table: first push latency, fill to full, refused fifth push, drain in order.
    for (int i = 0; i < 9; i++) begin
      cyc("tbl", vt[i].iv, vt[i].ins, vt[i].p4, vt[i].ordy, 1'b0);
      chk($sformatf("tbl%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("tbl%0d in_ready", i),  {31'b0, in_ready},  {31'b0, vt[i].exp_ready});
      chk($sformatf("tbl%0d out_instr", i), out_instr, vt[i].exp_instr);
      chk($sformatf("tbl%0d out_pc4", i),   out_pc4,   vt[i].exp_pc4);
      chk($sformatf("tbl%0d out_pc8", i),   out_pc8,   vt[i].exp_pc4 + 32'd4);
      chk($sformatf("tbl%0d count", i),     {29'b0, count}, vt[i].exp_count);
    end

    // Steady state push+pop at count=2 across pointer wrap.
    cyc("ss fill", 1'b1, 32'h10000001, 32'h00005004, 1'b0, 1'b0);
    cyc("ss fill", 1'b1, 32'h10000002, 32'h00005008, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("ss", 1'b1, 32'h20000000 + i, 32'h00006000 + 4 * i, 1'b1, 1'b0);
      chk("ss count", {29'b0, count}, 32'd2);
    end
    chk("ss head", out_instr, 32'h20000008);

    // Flush at count=3 with a concurrent push and pop.
    cyc("fl fill", 1'b1, 32'h30000001, 32'h00007004, 1'b0, 1'b0);
    chk("fl pre count", {29'b0, count}, 32'd3);
    cyc("fl", 1'b1, 32'hBADBAD01, 32'h00007008, 1'b1, 1'b1);
    chk("fl count", {29'b0, count}, 32'd0);
    chk("fl out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("fl idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("fl lost word", {31'b0, out_instr == 32'hBADBAD01}, 32'd0);
    end

    // Asynchronous reset between edges with count=2 and live handshakes.
    cyc("ar fill", 1'b1, 32'h40000001, 32'h00008004, 1'b0, 1'b0);
    cyc("ar fill", 1'b1, 32'h40000002, 32'h00008008, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h4000000F; in_pc4 = 32'h0000800C; out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("ar out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar count",     {29'b0, count},     32'd0);
    chk("ar in_ready",  {31'b0, in_ready},  32'd1);
    chk("ar out_instr", out_instr,          32'd0);
    chk("ar out_pc8",   out_pc8,            32'd4);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    cyc("ar push", 1'b1, 32'h08000C00, 32'h00009004, 1'b0, 1'b0);
    chk("ar new head",  out_instr, 32'h08000C00);
    chk("ar new count", {29'b0, count}, 32'd1);
    cyc("ar pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ar sole", {31'b0, out_valid}, 32'd0);

    // PC+8 wraps modulo 2^32.
    cyc("pc wrap", 1'b1, 32'h00000013, 32'hFFFFFFFC, 1'b0, 1'b0);
    chk("pc8 wrap", out_pc8, 32'h00000000);
    cyc("pc wrap pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full queue with decode ready: pop happens, push refused, in_ready back next cycle.
    for (int i = 0; i < DEPTH; i++) cyc("fr fill", 1'b1, 32'h50000000 + i, 32'h0000A000 + 4 * i, 1'b0, 1'b0);
    cyc("fr", 1'b1, 32'h5000FFFF, 32'h0000AFFF, 1'b1, 1'b0);
    chk("fr count", {29'b0, count}, 32'd3);
    chk("fr in_ready", {31'b0, in_ready}, 32'd1);

    // Randomized traffic against the queue model with shifting decode stall bias.
    for (int ph = 0; ph < 8; ph++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int i = 0; i < 60; i++) begin
        w = $urandom;
        cyc("rnd", $urandom_range(0, 3) != 0, w, {$urandom} & 32'hFFFFFFFC,
            $urandom_range(0, 3) < bias, $urandom_range(0, 39) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of entries; power of two, 2..16.
REQ-002 Parameter: AW, log2(DEPTH), pointer index width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 Port: in_valid  input  1  fetch stage presents a fetched instruction.
REQ-006 Port: in_instr  input  32  fetched instruction word.
REQ-007 Port: in_pc4  input  32  PC+4 of the fetched instruction.
REQ-008 Port: in_ready  output  1  queue accepts a push this cycle.
REQ-009 Port: out_valid  output  1  head entry available to decode.
REQ-010 Port: out_instr  output  32  head instruction word.
REQ-011 Port: out_pc4  output  32  head PC+4.
REQ-012 Port: out_pc8  output  32  head PC+8, equal to out_pc4+4, modulo 2^32.
REQ-013 Port: out_ready  input  1  decode consumes the head this cycle (0 = decode stall).
REQ-014 Port: flush  input  1  branch/jump redirect; discard all entries.
REQ-015 Port: count  output  AW+1  current number of valid entries, 0..DEPTH.

Function
REQ-016 Storage: DEPTH entries of {instr[31:0], pc4[31:0]}; read/write pointers AW+1 bits wide, wrap modulo 2*DEPTH.
REQ-017 Push: occurs when in_valid=1, in_ready=1 and flush=0; entry written at wr_ptr; wr_ptr increments.
REQ-018 Pop: occurs when out_valid=1, out_ready=1 and flush=0; rd_ptr increments.
REQ-019 Empty: wr_ptr==rd_ptr. Full: index bits equal, MSBs differ.
REQ-020 in_ready=!full, combinational from registered pointers only; no dependence on out_ready (no full-pass-through).
REQ-021 out_valid=!empty; no empty bypass; a push becomes visible on out_valid one cycle after the push edge.
REQ-022 While empty: out_instr=0x00000000 (NOP), out_pc4=0, out_pc8=4.
REQ-023 Simultaneous push and pop, neither full nor empty: both occur; count unchanged.
REQ-024 Full with out_ready=1: pop occurs, push refused that cycle; in_ready=1 next cycle.
REQ-025 Empty with in_valid=1: push occurs; out_valid stays 0 that cycle.
REQ-026 Flush: next edge sets rd_ptr=wr_ptr=0 and count=0. Push and pop in the same cycle are suppressed, so the entry is lost and the head is not consumed.
REQ-027 Pointer wrap: entry order preserved across wrap; FIFO order strictly maintained.
REQ-028 count equals wr_ptr-rd_ptr (modulo 2*DEPTH) at all times.
REQ-029 Storage contents never change except at a push.

Reset
REQ-030 reset=0 asynchronously forces rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, out_instr=0, out_pc4=0, out_pc8=4, with no clock edge required.
REQ-031 Storage array is not required to clear on reset; outputs are gated by REQ-022.
REQ-032 Reset asserted mid-operation discards all entries, and any push or pop that cycle is lost.
REQ-033 After reset deasserts, the first push is accepted on the first rising edge with in_valid=1.

Verification
REQ-034 Push 0x24020001/pc4 0x00003004, out_ready=0 -> next cycle out_valid=1, out_instr=0x24020001, out_pc4=0x00003004, out_pc8=0x00003008, count=1.
REQ-035 Push 5 entries with out_ready=0, DEPTH=4 -> in_ready=0 after 4th, 5th refused, count=4; then pop 4 -> entries emerge in push order, out_instr=0 after last.
REQ-036 Hold count=2, drive in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap, output order matches push order.
REQ-037 count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pushed word never appears.
REQ-038 count=2, drop reset to 0 between edges -> out_valid=0, count=0, in_ready=1 immediately; after release, push 0x08000C00 -> appears next cycle as the sole entry.
REQ-039 Head out_pc4=0xFFFFFFFC -> out_pc8=0x00000000 (wrap modulo 2^32).
